uart_cmd_frame_parser: RTL

- Byte-stream command-frame parser between the UART receiver and the DDS/PWM control registers of dds_sample_top.
- Frame format: HEADER, 11 payload bytes (func, ch, sta, duty, pulse_H, pulse_L, num, pat[31:24..7:0]), CRC-8, TAIL.
- Outputs a validated command strobe with decoded fields, plus NUM_CH persistent channel-enable bits.
- Successor to the fixed single-layout decoder: channel count, framing bytes, CRC polynomial and timeout are parametrised; adds error reporting and an error counter.

---
 rtl/dds_cmd_pkg.sv | 34 +++
 rtl/crc8_byte.sv | 19 +
 rtl/uart_cmd_frame_parser.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/dds_cmd_pkg.sv
// Shared types and constants for the UART command-frame parser.
package dds_cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CRC     = 2'd2,
    ST_TAIL    = 2'd3
  } state_e;

  localparam logic [1:0] ERR_TIMEOUT = 2'd0;
  localparam logic [1:0] ERR_CRC     = 2'd1;
  localparam logic [1:0] ERR_TAIL    = 2'd2;
  localparam logic [1:0] ERR_CH      = 2'd3;

  localparam logic [7:0] FUNC_CFG = 8'h01;
  localparam logic [7:0] FUNC_EN  = 8'h02;

  localparam int PAYLOAD_LEN = 11;
  localparam int IDX_W       = 4;

  // First payload byte sits in the MSBs so a byte array casts straight onto it.
  typedef struct packed {
    logic [7:0]  func;
    logic [7:0]  ch;
    logic [7:0]  sta;
    logic [7:0]  duty;
    logic [7:0]  pulse_h;
    logic [7:0]  pulse_l;
    logic [7:0]  num;
    logic [31:0] pat;
  } payload_t;

endpackage

// File: rtl/crc8_byte.sv
// One-byte CRC-8 update, MSB first, no reflection, no final XOR.
module crc8_byte #(
  parameter logic [7:0] CRC_POLY = 8'h07
) (
  input  logic [7:0] i_crc,
  input  logic [7:0] i_data,
  output logic [7:0] o_crc
);

  always_comb begin
    logic [7:0] c;
    c = i_crc ^ i_data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    o_crc = c;
  end

endmodule

// File: rtl/uart_cmd_frame_parser.sv
// Frame decoder: HEADER, 11 payload bytes, CRC-8, TAIL -> command strobe and channel enables.
// Define FRAME_TIMEOUT_EN to abandon a partial frame after TIMEOUT_CYC idle cycles.
module uart_cmd_frame_parser
  import dds_cmd_pkg::*;
#(
  parameter int         NUM_CH      = 8,
  parameter int         CH_W        = $clog2(NUM_CH + 1),
  parameter logic [7:0] HEADER      = 8'h55,
  parameter logic [7:0] TAIL        = 8'hAA,
  parameter logic [7:0] CRC_POLY    = 8'h07,
  parameter logic [7:0] CRC_INIT    = 8'h00,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              cmd_valid,
  output logic [7:0]        cmd_func,
  output logic [CH_W-1:0]   cmd_ch,
  output logic              cmd_sta,
  output logic [7:0]        cmd_duty,
  output logic [15:0]       cmd_pulse,
  output logic [7:0]        cmd_num,
  output logic [31:0]       cmd_pat,
  output logic [NUM_CH-1:0] ch_en,
  output logic              frame_err,
  output logic [1:0]        err_code,
  output logic [15:0]       err_cnt
);

  state_e                             r_state, w_state_nxt;
  logic [IDX_W-1:0]                   r_idx;
  logic [7:0]                         r_crc, w_crc_upd;
  logic                               r_crc_ok;
  logic [PAYLOAD_LEN-1:0][7:0]        r_pay;
  payload_t                           w_pay;
  logic                               w_ch_bad, w_commit, w_err;
  logic [1:0]                         w_err_code;

  logic                               r_cmd_valid, r_frame_err, r_cmd_sta;
  logic [7:0]                         r_cmd_func, r_cmd_duty, r_cmd_num;
  logic [CH_W-1:0]                    r_cmd_ch;
  logic [15:0]                        r_cmd_pulse, r_err_cnt;
  logic [31:0]                        r_cmd_pat;
  logic [NUM_CH-1:0]                  r_ch_en;
  logic [1:0]                         r_err_code;
  logic                               w_unused;

  crc8_byte #(.CRC_POLY(CRC_POLY)) u_crc (
    .i_crc  (r_crc),
    .i_data (rx_data),
    .o_crc  (w_crc_upd)
  );

  assign w_pay    = payload_t'(r_pay);
  assign w_ch_bad = (w_pay.ch == 8'd0) || ({1'b0, w_pay.ch} > 9'(NUM_CH));
  assign w_unused = ^{w_pay.sta[7:1], 32'(TIMEOUT_CYC)};

`ifdef FRAME_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] r_to_cnt;
  logic            w_timeout;

  // A byte in the same cycle clears the counter and outranks the timeout.
  assign w_timeout = (r_state != ST_IDLE) && (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)                          r_to_cnt <= '0;
    else if (rx_valid || r_state == ST_IDLE) r_to_cnt <= '0;
    else                                     r_to_cnt <= r_to_cnt + 1'b1;
  end
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= ST_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    w_err       = 1'b0;
    w_err_code  = ERR_TIMEOUT;
    if (rx_valid) begin
      case (r_state)
        ST_IDLE:    if (rx_data == HEADER) w_state_nxt = ST_PAYLOAD;
        ST_PAYLOAD: if (r_idx == IDX_W'(PAYLOAD_LEN - 1)) w_state_nxt = ST_CRC;
        ST_CRC:     w_state_nxt = ST_TAIL;
        ST_TAIL: begin
          w_state_nxt = ST_IDLE;
          if (rx_data != TAIL) begin
            w_err = 1'b1; w_err_code = ERR_TAIL;
          end else if (!r_crc_ok) begin
            w_err = 1'b1; w_err_code = ERR_CRC;
          end else if (w_ch_bad) begin
            w_err = 1'b1; w_err_code = ERR_CH;
          end else begin
            w_commit = 1'b1;
          end
        end
        default:    w_state_nxt = ST_IDLE;
      endcase
    end
`ifdef FRAME_TIMEOUT_EN
    else if (w_timeout) begin
      w_state_nxt = ST_IDLE;
      w_err       = 1'b1;
      w_err_code  = ERR_TIMEOUT;
    end
`endif
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_idx       <= '0;
      r_crc       <= '0;
      r_crc_ok    <= 1'b0;
      r_pay       <= '0;
      r_cmd_valid <= 1'b0;
      r_frame_err <= 1'b0;
      r_cmd_func  <= '0;
      r_cmd_ch    <= '0;
      r_cmd_sta   <= 1'b0;
      r_cmd_duty  <= '0;
      r_cmd_pulse <= '0;
      r_cmd_num   <= '0;
      r_cmd_pat   <= '0;
      r_ch_en     <= '0;
      r_err_code  <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_cmd_valid <= w_commit;
      r_frame_err <= w_err;
      if (rx_valid) begin
        case (r_state)
          ST_IDLE: if (rx_data == HEADER) begin
            r_crc <= CRC_INIT;
            r_idx <= '0;
          end
          ST_PAYLOAD: begin
            r_pay[IDX_W'(PAYLOAD_LEN - 1) - r_idx] <= rx_data;
            r_crc <= w_crc_upd;
            r_idx <= r_idx + 1'b1;
          end
          ST_CRC:  r_crc_ok <= (rx_data == r_crc);
          default: ;
        endcase
      end
      if (w_commit) begin
        r_cmd_func  <= w_pay.func;
        r_cmd_ch    <= w_pay.ch[CH_W-1:0];
        r_cmd_sta   <= w_pay.sta[0];
        r_cmd_duty  <= w_pay.duty;
        r_cmd_pulse <= {w_pay.pulse_h, w_pay.pulse_l};
        r_cmd_num   <= w_pay.num;
        r_cmd_pat   <= w_pay.pat;
        for (int k = 0; k < NUM_CH; k++) begin
          if (w_pay.func == FUNC_EN && w_pay.ch == 8'(k + 1)) r_ch_en[k] <= w_pay.sta[0];
        end
      end
      if (w_err) begin
        r_err_code <= w_err_code;
        if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
      end
    end
  end

  assign cmd_valid = r_cmd_valid;
  assign cmd_func  = r_cmd_func;
  assign cmd_ch    = r_cmd_ch;
  assign cmd_sta   = r_cmd_sta;
  assign cmd_duty  = r_cmd_duty;
  assign cmd_pulse = r_cmd_pulse;
  assign cmd_num   = r_cmd_num;
  assign cmd_pat   = r_cmd_pat;
  assign ch_en     = r_ch_en;
  assign frame_err = r_frame_err;
  assign err_code  = r_err_code;
  assign err_cnt   = r_err_cnt;

endmodule
